me_control: RTL and testbench
=============================

# me_control

Sequencer for the 16-PE systolic motion-estimation datapath. After `start`, it walks the 256 candidate displacements of a 16x16 reference block inside a 31x31 search window. It drives the reference-ROM and the two search-ROM read addresses, the per-PE accumulate-restart and operand-select strobes, and the comparator capture strobe with the candidate motion vector. It sits between the `ROM_R`/`ROM_S` memories and the PE array/comparator inside `top`, and owns `completed`.

## Interface
- `N_PE`, 16, number of PEs; only 16 is supported.
- `R_AW`, 8, reference ROM address width (16x16 block, row*16+col).
- `S_AW`, 10, search ROM address width (32x32 storage, row*32+col, col 0..30 used).
- `clock`  in  1  single clock, rising edge.
- `reset_n`  in  1  reset, synchronous and active-low.
- `start`  in  1  level request; sampled only in IDLE.
- `AddressR`  out  R_AW  reference ROM address.
- `AddressS1`  out  S_AW  search ROM port 1 address (left stream).
- `AddressS2`  out  S_AW  search ROM port 2 address (right stream).
- `S1S2mux`  out  16  bit k=1: PE k takes S1; bit k=0: PE k takes S2.
- `newDist`  out  16  bit k=1: PE k restarts its accumulation on this cycle.
- `cmp_valid`  out  1  comparator captures the PE selected by `cmp_pe`.
- `cmp_pe`  out  4  index of the PE whose finished SAD is valid.
- `motionX`, `motionY`  out  4  signed candidate vector for the capture (-8..7).
- `completed`  out  1  search finished; held high in DONE.

## Operation
- FSM with states IDLE, RUN and DONE.
  - IDLE: if `start`=1, go to RUN and set count c=0.
  - RUN: c increments by 1 each cycle through 0..4111 (13-bit counter). After c=4111, go to DONE.
  - DONE: `completed`=1. Return to IDLE when `start`=0.
  - `start` is ignored in RUN and DONE.
- Decode c as v=c[11:8], i=c[7:4], j=c[3:0]. The drain phase is c=4096..4111.
- Address outputs are combinational from c and state:
  - `AddressR` = c[7:0] when c<4096, else 0.
  - `AddressS1` = (v+i)*32 + j when c<4096, else 0.
  - `AddressS2` = rowS2*32 + j + 16, where:
    - rowS2 = v+i-1 if i>0.
    - rowS2 = v+14 if i=0 and v>0.
    - rowS2 = 30 if c>=4096.
    - `AddressS2` = 0 if c<16.
- Control for count c is computed from c and registered, so it appears one cycle after the addresses for the same c. This aligns it with the synchronous ROM read data.
  - `S1S2mux[k]` = (j >= k). During drain, j = c-4096.
  - `newDist[k]` = 1 iff 0 <= c-k <= 4095 and (c-k)[7:0] = 0.
  - `cmp_valid` = 1 iff some k in 0..15 satisfies 256 <= c-k <= 4096 and (c-k)[7:0] = 0. At most one k qualifies.
  - On a capture: `cmp_pe` = k, `motionX` = k-8, `motionY` = ((c-k)>>8) - 9.
  - When `cmp_valid`=0: `cmp_pe`, `motionX` and `motionY` = 0.
- Exactly 256 capture pulses per run, one per (k, v') pair.
- Outside RUN and the single trailing control cycle, all control outputs are 0. Addresses are 0 outside RUN.

## Timing
- Reset (`reset_n`=0 at a rising edge): state=IDLE, c=0, and every output is 0 on the next cycle, including `completed`. Reset mid-RUN aborts with no further capture pulses.
- `start` sampled high in IDLE at edge t:
  - c=0 is presented in cycle t+1.
  - c=4111 is presented in cycle t+4112.
  - The first DONE cycle is t+4113. In that cycle `completed` rises and the registered control for c=4111 is emitted (the final capture, k=15).
- `completed` stays high while `start`=1. Once `start`=0 it drops 1 cycle later (IDLE).
- Back-to-back runs need at least one IDLE cycle with `start`=0.

## Test plan
- Reset then `start`=1 held: check address outputs at the three points below, and `completed` rises exactly 4113 cycles after `start` is sampled.
  - c=0: R=0, S1=0, S2=0.
  - c=17: R=17, S1=33, S2=17.
  - c=4095: R=255, S1=975, S2=959.
- Drain: c=4096 gives S2=976 and R=S1=0. One cycle later `S1S2mux`=16'h0001. For c=4111 the registered mux value is 16'hFFFF.
- Capture sweep:
  - First pulse is for c=256: `cmp_pe`=0, vector (-8,-8).
  - Pulse for c=4111: `cmp_pe`=15, vector (7,7).
  - Total of 256 pulses. Every (X,Y) pair in -8..7 appears once.
- `newDist` scoreboard: 16'h0001 for c=0, 16'h0002 for c=1, 16'h0001 for c=256. `newDist` is 0 for c=4111.
- Assert `reset_n`=0 at c=1000: next cycle all outputs are 0 and the state is IDLE. Re-run with `start`: same results as the clean run.
- With `start` held high after DONE, `completed` stays 1 for 100 cycles. Drop `start`: IDLE, and a new `start` launches a run from c=0.

Source files
------------

// File: rtl/me_control.sv
// Sequencer for the 16-PE systolic motion-estimation array: walks 256 candidate
// displacements, drives ROM addresses, per-PE strobes and comparator captures.
module me_control #(
    parameter int N_PE = 16,
    parameter int R_AW = 8,
    parameter int S_AW = 10
) (
    input  logic                   clock,
    input  logic                   reset_n,
    input  logic                   start,
    output logic [R_AW-1:0]        AddressR,
    output logic [S_AW-1:0]        AddressS1,
    output logic [S_AW-1:0]        AddressS2,
    output logic [N_PE-1:0]        S1S2mux,
    output logic [N_PE-1:0]        newDist,
    output logic                   cmp_valid,
    output logic [3:0]             cmp_pe,
    output logic signed [3:0]      motionX,
    output logic signed [3:0]      motionY,
    output logic                   completed
);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    localparam logic [12:0] C_LAST = 13'd4111;

    state_t      state;
    logic [12:0] c;
    logic [3:0]  v, i, j;
    logic        drain;

    assign v     = c[11:8];
    assign i     = c[7:4];
    assign j     = c[3:0];
    assign drain = c[12];

    // Address generation: S1 streams the current row, S2 the previous one
    // offset by 16 columns (wrapping to v+14 at the top of each band).
    logic [4:0] row_s1, row_s2;

    always_comb begin
        AddressR  = '0;
        AddressS1 = '0;
        AddressS2 = '0;
        row_s1    = 5'(v) + 5'(i);
        row_s2    = '0;
        if (state == RUN) begin
            if (!drain) begin
                AddressR  = R_AW'(c[7:0]);
                AddressS1 = S_AW'({row_s1, 1'b0, j});
                if (i != 4'd0) row_s2 = row_s1 - 5'd1;
                else           row_s2 = 5'(v) + 5'd14;
                if (c[12:4] != 9'd0) AddressS2 = S_AW'({row_s2, 1'b1, j});
            end else begin
                AddressS2 = S_AW'({5'd30, 1'b1, j});
            end
        end
    end

    // Next-cycle control for count c. The only PE k that can align with a
    // 256-boundary is k = c[7:0], so everything reduces to slices of c.
    logic [N_PE-1:0] mux_n, nd_n;
    logic            cap_n;
    logic [4:0]      my5;

    always_comb begin
        for (int k = 0; k < N_PE; k++) mux_n[k] = (int'(j) >= k);
        nd_n  = (!drain && i == 4'd0) ? (N_PE'(1) << j) : '0;
        cap_n = (i == 4'd0) && (c[12:8] >= 5'd1) && (c[12:8] <= 5'd16);
        my5   = c[12:8] - 5'd9;
    end

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state     <= IDLE;
            c         <= '0;
            completed <= 1'b0;
            S1S2mux   <= '0;
            newDist   <= '0;
            cmp_valid <= 1'b0;
            cmp_pe    <= '0;
            motionX   <= '0;
            motionY   <= '0;
        end else begin
            case (state)
                IDLE: if (start) begin
                    state <= RUN;
                    c     <= '0;
                end
                RUN: begin
                    if (c == C_LAST) begin
                        state     <= DONE;
                        completed <= 1'b1;
                    end else begin
                        c <= c + 13'd1;
                    end
                end
                DONE: if (!start) begin
                    state     <= IDLE;
                    completed <= 1'b0;
                    c         <= '0;
                end
                default: state <= IDLE;
            endcase

            if (state == RUN) begin
                S1S2mux   <= mux_n;
                newDist   <= nd_n;
                cmp_valid <= cap_n;
                cmp_pe    <= cap_n ? j : 4'd0;
                motionX   <= cap_n ? signed'({~j[3], j[2:0]}) : 4'sd0;
                motionY   <= cap_n ? signed'(my5[3:0]) : 4'sd0;
            end else begin
                S1S2mux   <= '0;
                newDist   <= '0;
                cmp_valid <= 1'b0;
                cmp_pe    <= '0;
                motionX   <= '0;
                motionY   <= '0;
            end
        end
    end

endmodule

// File: tb/tb_me_control.sv
// Self-checking bench for me_control: full-run reference model per cycle,
// capture scoreboard, reset abort, DONE hold and back-to-back runs.
module tb_me_control;

    logic              clock = 1'b0;
    logic              reset_n = 1'b0;
    logic              start = 1'b0;
    logic [7:0]        AddressR;
    logic [9:0]        AddressS1, AddressS2;
    logic [15:0]       S1S2mux, newDist;
    logic              cmp_valid;
    logic [3:0]        cmp_pe;
    logic signed [3:0] motionX, motionY;
    logic              completed;

    int checks = 0;
    int errors = 0;

    me_control #(.N_PE(16), .R_AW(8), .S_AW(10)) dut (
        .clock(clock), .reset_n(reset_n), .start(start),
        .AddressR(AddressR), .AddressS1(AddressS1), .AddressS2(AddressS2),
        .S1S2mux(S1S2mux), .newDist(newDist), .cmp_valid(cmp_valid),
        .cmp_pe(cmp_pe), .motionX(motionX), .motionY(motionY),
        .completed(completed)
    );

    always #5 clock = ~clock;

    function automatic logic [73:0] actual();
        return {AddressR, AddressS1, AddressS2, S1S2mux, newDist,
                cmp_valid, cmp_pe, motionX, motionY, completed};
    endfunction

    // ca: count whose addresses are shown (-1 none); cc: count whose
    // registered control is shown (-1 none); done: completed flag.
    function automatic logic [73:0] exp_out(input int ca, input int cc, input bit done);
        logic [7:0]  r;
        logic [9:0]  s1, s2;
        logic [15:0] mx, nd;
        logic        vl;
        logic [3:0]  pe, x, y;
        int v, i, j, row, d;
        r = 0; s1 = 0; s2 = 0; mx = 0; nd = 0; vl = 0; pe = 0; x = 0; y = 0;
        if (ca >= 0) begin
            if (ca < 4096) begin
                v = ca / 256; i = (ca / 16) % 16; j = ca % 16;
                r  = 8'(ca % 256);
                s1 = 10'((v + i) * 32 + j);
                if (ca >= 16) begin
                    row = (i > 0) ? v + i - 1 : v + 14;
                    s2  = 10'(row * 32 + j + 16);
                end
            end else begin
                s2 = 10'(30 * 32 + (ca - 4096) + 16);
            end
        end
        if (cc >= 0) begin
            j = (cc < 4096) ? cc % 16 : cc - 4096;
            for (int k = 0; k < 16; k++) begin
                mx[k] = (j >= k);
                d = cc - k;
                if (d >= 0 && d <= 4095 && d % 256 == 0) nd[k] = 1'b1;
                if (d >= 256 && d <= 4096 && d % 256 == 0) begin
                    vl = 1'b1; pe = 4'(k); x = 4'(k - 8); y = 4'(d / 256 - 9);
                end
            end
        end
        return {r, s1, s2, mx, nd, vl, pe, x, y, done};
    endfunction

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic idle_check(input string tag, input int n);
        for (int t = 0; t < n; t++) begin
            step();
            checks++;
            if (actual() !== exp_out(-1, -1, 1'b0)) begin
                errors++;
                $display("FAIL %s idle: got %h want %h", tag, actual(), exp_out(-1, -1, 1'b0));
            end
        end
    endtask

    // Launch a run from IDLE and check every cycle until the first DONE cycle
    // (or until abort_at, where reset is applied). Leaves start = end_start.
    task automatic run_check(input string tag, input int abort_at, input bit end_start);
        int pulses = 0;
        int first_n = -1;
        int seen[16][16];
        int bad;
        logic [73:0] e;
        for (int a = 0; a < 16; a++) for (int b = 0; b < 16; b++) seen[a][b] = 0;
        start = 1'b1;
        step();
        for (int n = 0; n <= 4112; n++) begin
            if (abort_at >= 0 && n == abort_at) begin
                reset_n = 1'b0; start = 1'b0;
                step();
                reset_n = 1'b1;
                checks++;
                if (actual() !== exp_out(-1, -1, 1'b0)) begin
                    errors++;
                    $display("FAIL %s abort@%0d: got %h want zeros", tag, n, actual());
                end
                return;
            end
            e = exp_out((n <= 4111) ? n : -1, n - 1, n == 4112);
            checks++;
            if (actual() !== e) begin
                errors++;
                $display("FAIL %s cycle n=%0d: got %h want %h", tag, n, actual(), e);
            end
            if (cmp_valid) begin
                pulses++;
                if (first_n < 0) first_n = n;
                seen[int'(motionX) + 8][int'(motionY) + 8]++;
            end
            case (n)
                0: begin checks++; if ({AddressR, AddressS1, AddressS2} !== {8'd0, 10'd0, 10'd0}) begin
                    errors++; $display("FAIL %s addr c=0: got %0d/%0d/%0d want 0/0/0", tag, AddressR, AddressS1, AddressS2); end end
                1: begin checks++; if (newDist !== 16'h0001) begin
                    errors++; $display("FAIL %s newDist c=0: got %h want 0001", tag, newDist); end end
                2: begin checks++; if (newDist !== 16'h0002) begin
                    errors++; $display("FAIL %s newDist c=1: got %h want 0002", tag, newDist); end end
                17: begin checks++; if ({AddressR, AddressS1, AddressS2} !== {8'd17, 10'd33, 10'd17}) begin
                    errors++; $display("FAIL %s addr c=17: got %0d/%0d/%0d want 17/33/17", tag, AddressR, AddressS1, AddressS2); end end
                257: begin checks++; if ({newDist, cmp_valid, cmp_pe, motionX, motionY} !== {16'h0001, 1'b1, 4'd0, 4'h8, 4'h8}) begin
                    errors++; $display("FAIL %s ctrl c=256: got nd=%h v=%b pe=%0d (%0d,%0d) want 0001 1 0 (-8,-8)", tag, newDist, cmp_valid, cmp_pe, motionX, motionY); end end
                4095: begin checks++; if ({AddressR, AddressS1, AddressS2} !== {8'd255, 10'd975, 10'd959}) begin
                    errors++; $display("FAIL %s addr c=4095: got %0d/%0d/%0d want 255/975/959", tag, AddressR, AddressS1, AddressS2); end end
                4096: begin checks++; if ({AddressR, AddressS1, AddressS2} !== {8'd0, 10'd0, 10'd976}) begin
                    errors++; $display("FAIL %s addr c=4096: got %0d/%0d/%0d want 0/0/976", tag, AddressR, AddressS1, AddressS2); end end
                4097: begin checks++; if (S1S2mux !== 16'h0001) begin
                    errors++; $display("FAIL %s mux c=4096: got %h want 0001", tag, S1S2mux); end end
                4111: begin checks++; if (completed !== 1'b0) begin
                    errors++; $display("FAIL %s completed early: got %b want 0", tag, completed); end end
                4112: begin checks++; if ({completed, S1S2mux, newDist, cmp_valid, cmp_pe, motionX, motionY} !== {1'b1, 16'hFFFF, 16'h0000, 1'b1, 4'd15, 4'd7, 4'd7}) begin
                    errors++; $display("FAIL %s final c=4111: got cpl=%b mux=%h nd=%h v=%b pe=%0d (%0d,%0d) want 1 FFFF 0000 1 15 (7,7)", tag, completed, S1S2mux, newDist, cmp_valid, cmp_pe, motionX, motionY); end end
                default: ;
            endcase
            if (n < 4112) begin
                start = 1'($urandom_range(0, 1));
                step();
            end
        end
        start = end_start;
        checks++;
        if (pulses != 256 || first_n != 257) begin
            errors++;
            $display("FAIL %s pulses: got %0d first@%0d want 256 first@257", tag, pulses, first_n);
        end
        bad = 0;
        for (int a = 0; a < 16; a++) for (int b = 0; b < 16; b++) if (seen[a][b] != 1) bad++;
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL %s vector coverage: got %0d pairs not seen once want 0", tag, bad);
        end
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        for (int t = 0; t < 3; t++) begin
            start = 1'($urandom_range(0, 1));
            step();
        end
        start = 1'b1;
        step();
        checks++;
        if (actual() !== exp_out(-1, -1, 1'b0)) begin
            errors++;
            $display("FAIL reset state: got %h want zeros", actual());
        end
        reset_n = 1'b1; start = 1'b0;
        idle_check("reset", 2 + $urandom_range(0, 3));
    endtask

    task automatic test_full_run();
        run_check("full", -1, 1'b0);
        idle_check("full_end", 3);
    endtask

    task automatic test_abort();
        run_check("abort1000", 1000, 1'b0);
        idle_check("abort1000", 2);
        run_check("rerun", -1, 1'b0);
        idle_check("rerun_end", 1);
        run_check("abort_rand", $urandom_range(1, 4112), 1'b0);
        idle_check("abort_rand", 2);
    endtask

    task automatic test_done_hold();
        run_check("hold", -1, 1'b1);
        for (int t = 0; t < 100; t++) begin
            step();
            start = 1'b1;
            checks++;
            if (actual() !== exp_out(-1, -1, 1'b1)) begin
                errors++;
                $display("FAIL done_hold t=%0d: got %h want %h", t, actual(), exp_out(-1, -1, 1'b1));
            end
        end
        start = 1'b0;
        idle_check("hold_drop", 1);
        run_check("after_hold", -1, 1'b0);
    endtask

    task automatic test_back_to_back();
        idle_check("b2b_gap", 1);
        run_check("b2b", -1, 1'b0);
        idle_check("b2b_end", 1);
    endtask

    initial begin
        test_reset();
        test_full_run();
        test_abort();
        test_done_hold();
        test_back_to_back();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
